// File: rtl/oled_text_console.sv
// Character-cell text buffer feeding the OLED ASCII input: cursor handling for
// printables, CR, LF and BS, end-of-screen wrap or one-row scroll, and redraw pulses.
module oled_text_console #(
    parameter int NUM_ASCII_COL = 12,
    parameter int NUM_ASCII_ROW = 8,
    parameter int CHAR_BITS     = 8
) (
    input  logic                                              i_CLK,
    input  logic                                              i_RST_N,
    input  logic                                              i_VALID,
    input  logic [CHAR_BITS-1:0]                              i_CHAR,
    output logic                                              o_READY,
    input  logic                                              i_CLEAR,
    input  logic                                              i_SCROLL_EN,
    input  logic                                              i_OLED_READY,
    output logic                                              o_START,
    output logic [NUM_ASCII_COL*NUM_ASCII_ROW*CHAR_BITS-1:0]  o_ASCII,
    output logic [$clog2(NUM_ASCII_COL)-1:0]                  o_CURSOR_COL,
    output logic [$clog2(NUM_ASCII_ROW)-1:0]                  o_CURSOR_ROW
);
    localparam int N     = NUM_ASCII_COL * NUM_ASCII_ROW;
    localparam int COL_W = $clog2(NUM_ASCII_COL);
    localparam int ROW_W = $clog2(NUM_ASCII_ROW);

    localparam logic [COL_W-1:0]     LAST_COL = COL_W'(NUM_ASCII_COL - 1);
    localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(NUM_ASCII_ROW - 1);
    localparam logic [CHAR_BITS-1:0] C_SPACE  = CHAR_BITS'(8'h20);
    localparam logic [CHAR_BITS-1:0] C_TILDE  = CHAR_BITS'(8'h7E);
    localparam logic [CHAR_BITS-1:0] C_LF     = CHAR_BITS'(8'h0A);
    localparam logic [CHAR_BITS-1:0] C_CR     = CHAR_BITS'(8'h0D);
    localparam logic [CHAR_BITS-1:0] C_BS     = CHAR_BITS'(8'h08);

    typedef logic [NUM_ASCII_COL-1:0][CHAR_BITS-1:0] row_t;
    typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_CLEAR} state_t;

    localparam row_t BLANK_ROW = {NUM_ASCII_COL{C_SPACE}};

    state_t               state_q, state_d;
    row_t                 cells_q [NUM_ASCII_ROW];
    logic [ROW_W-1:0]     k_q, k_d;
    logic [ROW_W-1:0]     row_q, row_d, wr_row;
    logic [COL_W-1:0]     col_q, col_d, wr_col;
    logic [CHAR_BITS-1:0] wr_data;
    logic                 wr_en, set_dirty, newline;
    logic                 dirty_q, ready_q;
    logic                 start;

    assign start        = dirty_q && i_OLED_READY && (state_q == S_IDLE);
    assign o_START      = start;
    assign o_READY      = ready_q;
    assign o_CURSOR_COL = col_q;
    assign o_CURSOR_ROW = row_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        wr_en     = 1'b0;
        wr_row    = row_q;
        wr_col    = col_q;
        wr_data   = i_CHAR;
        set_dirty = 1'b0;
        newline   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // clear has priority; a coincident character is consumed and dropped
                if (i_CLEAR) begin
                    state_d = S_CLEAR;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else if (i_VALID) begin
                    if (i_CHAR >= C_SPACE && i_CHAR <= C_TILDE) begin
                        wr_en     = 1'b1;
                        set_dirty = 1'b1;
                        if (col_q == LAST_COL) newline = 1'b1;
                        else                   col_d   = col_q + 1'b1;
                    end else if (i_CHAR == C_LF) begin
                        newline = 1'b1;
                    end else if (i_CHAR == C_CR) begin
                        col_d = '0;
                    end else if (i_CHAR == C_BS) begin
                        if (col_q != '0) begin
                            col_d     = col_q - 1'b1;
                            wr_col    = col_q - 1'b1;
                            wr_en     = 1'b1;
                            wr_data   = C_SPACE;
                            set_dirty = 1'b1;
                        end else if (row_q != '0) begin
                            row_d     = row_q - 1'b1;
                            col_d     = LAST_COL;
                            wr_row    = row_q - 1'b1;
                            wr_col    = LAST_COL;
                            wr_en     = 1'b1;
                            wr_data   = C_SPACE;
                            set_dirty = 1'b1;
                        end
                    end
                    if (newline) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            if (i_SCROLL_EN) begin
                                state_d = S_SCROLL;
                                k_d     = '0;
                                row_d   = LAST_ROW;
                            end else begin
                                row_d = '0;
                            end
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
            end
            S_SCROLL, S_CLEAR: begin
                k_d = k_q + 1'b1;
                if (k_q == LAST_ROW) begin
                    state_d   = S_IDLE;
                    k_d       = '0;
                    set_dirty = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ready_q <= 1'b1;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ready_q <= (state_d == S_IDLE);
            // a write landing on the redraw edge keeps dirty set
            dirty_q <= set_dirty | (dirty_q & ~start);
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            for (int r = 0; r < NUM_ASCII_ROW; r++) cells_q[r] <= BLANK_ROW;
        end else begin
            case (state_q)
                S_IDLE:   if (wr_en) cells_q[wr_row][wr_col] <= wr_data;
                S_SCROLL: begin
                    if (k_q == LAST_ROW) cells_q[k_q] <= BLANK_ROW;
                    else                 cells_q[k_q] <= cells_q[k_q + 1'b1];
                end
                S_CLEAR:  cells_q[k_q] <= BLANK_ROW;
                default:  ;
            endcase
        end
    end

    for (genvar r = 0; r < NUM_ASCII_ROW; r++) begin : g_row
        for (genvar c = 0; c < NUM_ASCII_COL; c++) begin : g_col
            assign o_ASCII[(N-1-(r*NUM_ASCII_COL+c))*CHAR_BITS +: CHAR_BITS] = cells_q[r][c];
        end
    end
endmodule

// File: tb/tb_oled_text_console.sv
// Directed bench for oled_text_console: reference text-screen model, expected
// snapshots queued as characters are driven and compared once the DUT has settled.
module tb_oled_text_console;
    localparam int C  = 12;
    localparam int R  = 8;
    localparam int CB = 8;
    localparam int N  = C * R;
    localparam int W  = N * CB;

    typedef logic [W-1:0] wide_t;
    typedef struct {
        wide_t      ascii;
        logic [3:0] col;
        logic [2:0] row;
    } exp_t;

    logic          i_CLK = 1'b0;
    logic          i_RST_N = 1'b0;
    logic          i_VALID = 1'b0;
    logic [CB-1:0] i_CHAR = '0;
    logic          i_CLEAR = 1'b0;
    logic          i_SCROLL_EN = 1'b0;
    logic          i_OLED_READY = 1'b0;
    logic          o_READY;
    logic          o_START;
    wide_t         o_ASCII;
    logic [3:0]    o_CURSOR_COL;
    logic [2:0]    o_CURSOR_ROW;

    exp_t       exp_q[$];
    logic [7:0] m_buf [R][C];
    int         m_row, m_col;
    int         checks = 0, failures = 0;
    int         start_cnt = 0, start_busy = 0;

    always #5 i_CLK = ~i_CLK;

    oled_text_console #(.NUM_ASCII_COL(C), .NUM_ASCII_ROW(R), .CHAR_BITS(CB)) dut (
        .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_VALID(i_VALID), .i_CHAR(i_CHAR),
        .o_READY(o_READY), .i_CLEAR(i_CLEAR), .i_SCROLL_EN(i_SCROLL_EN),
        .i_OLED_READY(i_OLED_READY), .o_START(o_START), .o_ASCII(o_ASCII),
        .o_CURSOR_COL(o_CURSOR_COL), .o_CURSOR_ROW(o_CURSOR_ROW)
    );

    always @(posedge i_CLK) begin
        if (i_RST_N && o_START) begin
            start_cnt++;
            if (!o_READY) start_busy++;
        end
    end

    function automatic wide_t flat();
        wide_t v;
        v = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                v[(N-1-(r*C+c))*CB +: CB] = m_buf[r][c];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) m_buf[r][c] = 8'h20;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_newline(input bit scr);
        m_col = 0;
        if (m_row == R-1) begin
            if (scr) begin
                for (int r = 0; r < R-1; r++) m_buf[r] = m_buf[r+1];
                for (int c = 0; c < C; c++) m_buf[R-1][c] = 8'h20;
                m_row = R-1;
            end else begin
                m_row = 0;
            end
        end else begin
            m_row++;
        end
    endtask

    task automatic model_char(input logic [7:0] ch, input bit scr);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            m_buf[m_row][m_col] = ch;
            if (m_col == C-1) model_newline(scr);
            else              m_col++;
        end else if (ch == 8'h0A) begin
            model_newline(scr);
        end else if (ch == 8'h0D) begin
            m_col = 0;
        end else if (ch == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_buf[m_row][m_col] = 8'h20;
            end else if (m_row > 0) begin
                m_row--;
                m_col = C-1;
                m_buf[m_row][m_col] = 8'h20;
            end
        end
    endtask

    task automatic chk(input string tag, input wide_t obs, input wide_t expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.ascii = flat();
        e.col   = 4'(m_col);
        e.row   = 3'(m_row);
        exp_q.push_back(e);
    endtask

    task automatic check_snap(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, wide_t'(0), wide_t'(1));
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_ascii"}, o_ASCII, e.ascii);
        chk({tag, "_col"}, wide_t'(o_CURSOR_COL), wide_t'(e.col));
        chk({tag, "_row"}, wide_t'(o_CURSOR_ROW), wide_t'(e.row));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge i_CLK);
    endtask

    task automatic send(input logic [7:0] ch, input bit push);
        int t;
        t = 0;
        @(negedge i_CLK);
        while (!o_READY && t < 50) begin
            t++;
            @(negedge i_CLK);
        end
        if (!o_READY) chk("ready_timeout", wide_t'(o_READY), wide_t'(1));
        i_VALID = 1'b1;
        i_CHAR  = ch;
        @(posedge i_CLK);
        #1 i_VALID = 1'b0;
        model_char(ch, i_SCROLL_EN);
        if (push) push_exp();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        @(negedge i_CLK);
        while (!o_READY && n < 50) begin
            n++;
            @(negedge i_CLK);
        end
    endtask

    task automatic do_clear(input bit with_valid, input string tag);
        int busy;
        @(negedge i_CLK);
        i_CLEAR = 1'b1;
        i_VALID = with_valid;
        i_CHAR  = "Q";
        @(posedge i_CLK);
        #1;
        i_CLEAR = 1'b0;
        i_VALID = 1'b0;
        model_reset();
        count_busy(busy);
        chk({tag, "_busy"}, wide_t'(busy), wide_t'(R));
        push_exp();
        check_snap(tag);
    endtask

    initial begin
        int busy, s0;
        model_reset();
        wait_cycles(2);
        push_exp();
        check_snap("reset");
        chk("reset_ready", wide_t'(o_READY), wide_t'(1));
        chk("reset_start", wide_t'(o_START), wide_t'(0));
        i_RST_N = 1'b1;

        send("A", 0);
        send("B", 1);
        check_snap("ab");
        chk("ab_no_start_oled_busy", wide_t'(start_cnt), wide_t'(0));
        i_OLED_READY = 1'b1;
        wait_cycles(3);
        chk("ab_one_start", wide_t'(start_cnt), wide_t'(1));
        i_OLED_READY = 1'b0;

        send(8'h0D, 0);
        send("C", 0);
        send(8'h0A, 0);
        send(8'h01, 0);
        send("D", 1);
        check_snap("cr_lf_ign");

        do_clear(1'b1, "clear_q");

        i_SCROLL_EN = 1'b1;
        for (int i = 0; i < N-1; i++) send("X", 0);
        send("X", 0);
        count_busy(busy);
        chk("scroll_busy", wide_t'(busy), wide_t'(R));
        push_exp();
        check_snap("scroll");
        send("Y", 1);
        check_snap("scroll_y");

        do_clear(1'b0, "clear2");
        i_SCROLL_EN = 1'b0;
        for (int i = 0; i < N; i++) send("X", 0);
        count_busy(busy);
        chk("wrap_busy", wide_t'(busy), wide_t'(0));
        push_exp();
        check_snap("wrap");
        send("Z", 1);
        check_snap("wrap_z");

        do_clear(1'b0, "clear3");
        i_OLED_READY = 1'b1;
        wait_cycles(3);
        i_OLED_READY = 1'b0;
        send("H", 0);
        send("I", 0);
        send(8'h08, 0);
        send(8'h08, 1);
        check_snap("bs");
        s0 = start_cnt;
        i_OLED_READY = 1'b1;
        wait_cycles(3);
        chk("bs_dirty", wide_t'(start_cnt - s0), wide_t'(1));
        i_OLED_READY = 1'b0;
        s0 = start_cnt;
        send(8'h08, 1);
        check_snap("bs_noop");
        i_OLED_READY = 1'b1;
        wait_cycles(3);
        chk("bs_noop_clean", wide_t'(start_cnt - s0), wide_t'(0));
        i_OLED_READY = 1'b0;
        for (int i = 0; i < C; i++) send("K", 0);
        send(8'h08, 1);
        check_snap("bs_row");

        do_clear(1'b0, "clear4");
        i_SCROLL_EN = 1'b1;
        for (int i = 0; i < N; i++) send("X", 0);
        wait_cycles(3);
        i_RST_N = 1'b0;
        #1;
        model_reset();
        push_exp();
        check_snap("rst_mid");
        chk("rst_mid_ready", wide_t'(o_READY), wide_t'(1));
        chk("rst_mid_start", wide_t'(o_START), wide_t'(0));
        @(negedge i_CLK);
        i_RST_N = 1'b1;
        send("R", 1);
        check_snap("after_rst");

        chk("start_never_busy", wide_t'(start_busy), wide_t'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/oled_text_console.md
# oled_text_console

Parametrised character-cell text buffer that sits between a byte-stream source (UART, button logic, CPU) and the OLED_interface ASCII input. Accepts one character per valid/ready handshake, maintains a cursor, handles CR/LF/backspace, and either wraps to the top or scrolls up one text row when the screen fills. Drives the flattened ASCII vector and issues single-cycle redraw starts, gated by the interface's ready signal.

## Interface
- NUM_ASCII_COL, 12, character columns (≥2)
- NUM_ASCII_ROW, 8, character rows (≥2)
- CHAR_BITS, 8, bits per character cell
- i_CLK  in  1  system clock
- i_RST_N  in  1  asynchronous, active-low reset
- i_VALID  in  1  i_CHAR valid
- i_CHAR  in  CHAR_BITS  character code
- o_READY  out  1  registered; high only in IDLE
- i_CLEAR  in  1  clear-screen request, sampled in IDLE
- i_SCROLL_EN  in  1  1 = scroll at end of screen, 0 = wrap to (0,0); sampled at accept
- i_OLED_READY  in  1  OLED_interface ready
- o_START  out  1  one-cycle redraw pulse, to OLED_interface start
- o_ASCII  out  NUM_ASCII_COL*NUM_ASCII_ROW*CHAR_BITS  flattened buffer; cell (r,c) at bits [(N-1-(r*NUM_ASCII_COL+c))*CHAR_BITS +: CHAR_BITS], N = cell count (row 0 col 0 in MSBs)
- o_CURSOR_COL  out  $clog2(NUM_ASCII_COL)  cursor column
- o_CURSOR_ROW  out  $clog2(NUM_ASCII_ROW)  cursor row

## Operation
- States: IDLE, SCROLL, CLEAR.
- Accept = i_VALID & o_READY at a rising edge. Codes are handled as follows:
  - Printable 0x20–0x7E: write the cell at the cursor, then advance the column.
    - Past the last column: col=0, row+1.
    - Past the last row with i_SCROLL_EN=1: enter SCROLL.
    - Past the last row with i_SCROLL_EN=0: cursor (0,0), stay IDLE.
  - 0x0A (LF): col=0 and advance the row. End-of-screen handling is the same as for printables.
  - 0x0D (CR): col=0; buffer unchanged.
  - 0x08 (BS): the cursor steps back, then the cell at the new position is written 0x20.
    - col>0: col-1.
    - col=0, row>0: (row-1, NUM_ASCII_COL-1).
    - At (0,0): no-op.
  - Any other code: consumed and ignored.
- SCROLL: a row counter k runs 0..NUM_ASCII_ROW-1.
  - k < NUM_ASCII_ROW-1: row k ← row k+1.
  - k = NUM_ASCII_ROW-1: row k ← all 0x20, then return to IDLE.
  - Cursor is (NUM_ASCII_ROW-1, 0) from SCROLL entry.
- CLEAR: entered from IDLE when i_CLEAR=1.
  - Cursor goes to (0,0) at entry.
  - One row is filled with 0x20 per cycle, k = 0..NUM_ASCII_ROW-1, then return to IDLE.
- i_CLEAR and i_VALID both high in IDLE: clear wins. The character counts as consumed (handshake completed) and is discarded.
- i_CLEAR while in SCROLL or CLEAR: ignored.
- Dirty flag:
  - Set by any printable write, any BS that writes, and completion of SCROLL/CLEAR.
  - Not set by CR, by ignored codes, or by a BS no-op at (0,0).
- o_START fires when dirty & i_OLED_READY & state==IDLE; dirty clears on that edge. If a new write lands on the same edge, dirty stays set (set wins).
- Reset: every cell 0x20, cursor (0,0), state IDLE, k=0, dirty=0, o_READY=1, o_START=0.
- Asynchronous reset mid-SCROLL or mid-CLEAR aborts the operation; the buffer is restored to all 0x20.

## Timing
- Printable, LF, CR, BS with no end-of-screen event: cell and cursor are updated on the accept edge. o_READY stays 1, so back-to-back accepts run at one per cycle.
- End-of-screen in scroll mode: o_READY is 0 for exactly NUM_ASCII_ROW cycles after the accept edge, and 1 again on the following cycle.
  - The character written on the accept edge sits in the last row before shifting, so it ends up in row NUM_ASCII_ROW-2.
- CLEAR: o_READY is 0 for NUM_ASCII_ROW cycles after the sampling edge.
- o_START is high for exactly one cycle. Its earliest assertion is the cycle after the edge that sets dirty. It never asserts while o_READY=0.
- o_ASCII and the cursor outputs are direct register outputs; there is no combinational path from the inputs.

## Test plan
- Reset, then send "AB" on back-to-back cycles → o_ASCII top two bytes 0x41,0x42, rest 0x20; cursor (0,2); one o_START pulse once i_OLED_READY=1.
- Defaults, i_SCROLL_EN=1, send 96 × 'X' then 'Y' → after the 96th char: 8 cycles o_READY=0; rows 0–6 'X', row 7 spaces; cursor (7,0). 'Y' then lands at (7,0).
- Same fill with i_SCROLL_EN=0 → no busy cycles, cursor (0,0); the next 'Z' overwrites cell (0,0) only.
- Send "HI", 0x08, 0x08, 0x08 → cells (0,0),(0,1) = 0x20; cursor (0,0); the third BS sets no dirty.
- i_CLEAR with i_VALID ('Q') in the same cycle → 8 cycles busy, buffer all 0x20, 'Q' absent, cursor (0,0).
- Assert i_RST_N low on the 3rd cycle of SCROLL → all outputs at reset values immediately; the first accept after release completes normally.
